// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and coordinate types for the VGA timing block.
// VGA_FRAME_CNT_EN (defined elsewhere) enables the optional frame counter in vga_if/vga_timing.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    // Totals are kept as full-width ints so they can never wrap.
    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOT = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    typedef logic [9:0] coord_x_t;
    typedef logic [8:0] coord_y_t;
    typedef logic [9:0] cnt_t;

endpackage

// File: rtl/vga_if.sv
// Raster output bundle from vga_timing to the renderers and the VGA connector.
// With VGA_FRAME_CNT_EN defined the bundle also carries frame_cnt.
interface vga_if;
    import vga_pkg::*;

    logic     pix_en;
    coord_x_t vgax;
    coord_y_t vgay;
    logic     video_on;
    logic     hsync;
    logic     vsync;
    logic     update;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;

    modport master (output pix_en, vgax, vgay, video_on, hsync, vsync, update, frame_cnt);
    modport slave  (input  pix_en, vgax, vgay, video_on, hsync, vsync, update, frame_cnt);
`else
    modport master (output pix_en, vgax, vgay, video_on, hsync, vsync, update);
    modport slave  (input  pix_en, vgax, vgay, video_on, hsync, vsync, update);
`endif

endinterface

// File: rtl/vga_timing_pix_strobe.sv
// Pixel-rate strobe: a registered one-clock pulse every CLK_DIV system clocks (CLK_DIV 1..4).
module pix_strobe #(
    parameter int CLK_DIV = 2
) (
    input  logic clck,
    input  logic reset_n,
    output logic pix_en
);

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    logic [1:0] div_reg;
    logic       pix_en_reg;

    always_ff @(posedge clck or negedge reset_n) begin
        if (!reset_n) begin
            div_reg    <= '0;
            pix_en_reg <= 1'b0;
        end else begin
            pix_en_reg <= (div_reg == DIV_LAST);
            div_reg    <= (div_reg == DIV_LAST) ? 2'd0 : div_reg + 2'd1;
        end
    end

    assign pix_en = pix_en_reg;

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: h/v counters, sync, blanking, coordinates and a per-frame game tick.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame counter output.
module vga_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic  clck,
    input  logic  reset_n,
    vga_if.master vga
);
    import vga_pkg::*;

    localparam int LINE_LEN    = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int FRAME_LINES = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam cnt_t H_LAST = cnt_t'(LINE_LEN - 1);
    localparam cnt_t V_LAST = cnt_t'(FRAME_LINES - 1);
    localparam cnt_t H_VIS  = cnt_t'(H_ACTIVE);
    localparam cnt_t V_VIS  = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    logic     pix_en;
    cnt_t     hcnt_reg, vcnt_reg;
    cnt_t     hcnt_next, vcnt_next;
    logic     frame_wrap, vblank_start;
    logic     armed_reg;
    coord_x_t vgax_reg;
    coord_y_t vgay_reg;
    logic     video_on_reg, hsync_reg, vsync_reg, update_reg;

    pix_strobe #(.CLK_DIV(CLK_DIV)) u_pix_strobe (
        .clck    (clck),
        .reset_n (reset_n),
        .pix_en  (pix_en)
    );

    always_comb begin
        hcnt_next  = (hcnt_reg == H_LAST) ? '0 : hcnt_reg + 10'd1;
        vcnt_next  = vcnt_reg;
        frame_wrap = 1'b0;
        if (hcnt_reg == H_LAST) begin
            vcnt_next  = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 10'd1;
            frame_wrap = (vcnt_reg == V_LAST);
        end
        vblank_start = (hcnt_next == '0) && (vcnt_next == V_VIS);
    end

    // Outputs are computed from the next counter values so they never lag the raster position.
    // armed_reg holds off the game tick until the first frame after reset has completed.
    always_ff @(posedge clck or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_reg     <= '0;
            vcnt_reg     <= '0;
            armed_reg    <= 1'b0;
            vgax_reg     <= '0;
            vgay_reg     <= '0;
            video_on_reg <= 1'b0;
            hsync_reg    <= 1'b1;
            vsync_reg    <= 1'b1;
            update_reg   <= 1'b0;
        end else begin
            update_reg <= 1'b0;
            if (pix_en) begin
                hcnt_reg     <= hcnt_next;
                vcnt_reg     <= vcnt_next;
                video_on_reg <= (hcnt_next < H_VIS) && (vcnt_next < V_VIS);
                hsync_reg    <= !((hcnt_next >= HS_BEG) && (hcnt_next < HS_END));
                vsync_reg    <= !((vcnt_next >= VS_BEG) && (vcnt_next < VS_END));
                vgax_reg     <= (hcnt_next < H_VIS) ? hcnt_next : '0;
                vgay_reg     <= (vcnt_next < V_VIS) ? vcnt_next[8:0] : '0;
                if (frame_wrap)
                    armed_reg <= 1'b1;
                if (vblank_start && armed_reg)
                    update_reg <= 1'b1;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_reg;

    always_ff @(posedge clck or negedge reset_n) begin
        if (!reset_n)
            frame_cnt_reg <= '0;
        else if (pix_en && vblank_start && armed_reg)
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end

    assign vga.frame_cnt = frame_cnt_reg;
`endif

    assign vga.pix_en   = pix_en;
    assign vga.vgax     = vgax_reg;
    assign vga.vgay     = vgay_reg;
    assign vga.video_on = video_on_reg;
    assign vga.hsync    = hsync_reg;
    assign vga.vsync    = vsync_reg;
    assign vga.update   = update_reg;

endmodule
